// File: rtl/udp_img_packetizer.sv
// udp_img_packetizer
// Drains a camera byte FIFO into fixed-length UDP payloads. Once the FIFO holds
// a full packet it raises tx_req, and after tx_ack it serves tx_data_rd pulls:
// an optional 4-byte header (frame number, packet index), then PKT_LEN pixel
// bytes popped from the FIFO. A rising edge on cmos_vsync starts a new frame.
//
// Build option: define PKT_HDR_EN to prepend the 4-byte header
// (udp_len = PKT_LEN+4). Without it the header state is skipped and
// udp_len = PKT_LEN. Frame and packet counters exist in both builds.
//
// Ports
//   gmii_rx_clk      sole clock (also the FIFO read clock)
//   rst_n            asynchronous active-low reset
//   cmos_vsync       camera frame sync, asynchronous, synchronised here
//   fifo_data_count  FIFO read-side fill level
//   fifo_data        FIFO read data, valid 1 cycle after fifo_rd_en
//   fifo_rd_en       FIFO pop
//   tx_req / tx_ack  packet-ready request and its acceptance
//   tx_data_rd       one-byte pull from the transmitter
//   tx_data          pulled byte, valid 1 cycle after tx_data_rd
//   udp_len          payload length of every packet
//   frame_num        frame counter
//   pkt_err          1-cycle pulse when a payload pull finds the FIFO empty
//   dbg_state        current FSM state (IDLE=0 REQ=1 HDR=2 PAYLOAD=3 DONE=4)
//
// Handshake: tx_req is held in REQ until the cycle tx_ack is sampled high;
// after that each cycle with tx_data_rd high is one byte transfer whose data
// appears on tx_data exactly one cycle later, with no back-pressure.

module udp_img_packetizer #(
    parameter int PKT_LEN = 1024,
    parameter int CNT_W   = 11
) (
    input  logic             gmii_rx_clk,
    input  logic             rst_n,
    input  logic             cmos_vsync,
    input  logic [CNT_W-1:0] fifo_data_count,
    input  logic [7:0]       fifo_data,
    output logic             fifo_rd_en,
    output logic             tx_req,
    input  logic             tx_ack,
    input  logic             tx_data_rd,
    output logic [7:0]       tx_data,
    output logic [15:0]      udp_len,
    output logic [15:0]      frame_num,
    output logic             pkt_err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        HDR     = 3'd2,
        PAYLOAD = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [31:0] PKT_LEN_U = 32'(PKT_LEN);
    localparam logic [10:0] LAST_C    = 11'(PKT_LEN - 1);

    state_t      state_q, state_d;
    logic        vs_meta_q, vs_sync_q, vs_prev_q;
    logic        vs_rise;
    logic [15:0] frame_num_q, frame_num_d;
    logic [15:0] pkt_idx_q, pkt_idx_d;
    logic        clr_pend_q, clr_pend_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        pay_sel_q, pay_sel_d;
    logic        pkt_err_q, pkt_err_d;
    logic        fifo_empty;
    logic        level_ok;
`ifdef PKT_HDR_EN
    logic [15:0] hdr_frame_q, hdr_frame_d;
`endif

    // Two synchroniser flops, plus one more to remember the previous
    // synchronised level for edge detection.
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_meta_q <= 1'b0;
            vs_sync_q <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_meta_q <= cmos_vsync;
            vs_sync_q <= vs_meta_q;
            vs_prev_q <= vs_sync_q;
        end
    end

    assign vs_rise    = vs_sync_q & ~vs_prev_q;
    assign fifo_empty = (fifo_data_count == '0);
    assign level_ok   = (32'(fifo_data_count) >= PKT_LEN_U);

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_num_q <= 16'h0000;
            pkt_idx_q   <= 16'h0000;
            clr_pend_q  <= 1'b0;
            byte_cnt_q  <= 11'd0;
            tx_data_q   <= 8'h00;
            pay_sel_q   <= 1'b0;
            pkt_err_q   <= 1'b0;
`ifdef PKT_HDR_EN
            hdr_frame_q <= 16'h0000;
`endif
        end else begin
            state_q     <= state_d;
            frame_num_q <= frame_num_d;
            pkt_idx_q   <= pkt_idx_d;
            clr_pend_q  <= clr_pend_d;
            byte_cnt_q  <= byte_cnt_d;
            tx_data_q   <= tx_data_d;
            pay_sel_q   <= pay_sel_d;
            pkt_err_q   <= pkt_err_d;
`ifdef PKT_HDR_EN
            hdr_frame_q <= hdr_frame_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        frame_num_d = frame_num_q;
        pkt_idx_d   = pkt_idx_q;
        clr_pend_d  = clr_pend_q;
        byte_cnt_d  = byte_cnt_q;
        tx_data_d   = tx_data_q;
        pay_sel_d   = 1'b0;
        pkt_err_d   = 1'b0;
        fifo_rd_en  = 1'b0;
        tx_req      = 1'b0;
`ifdef PKT_HDR_EN
        hdr_frame_d = hdr_frame_q;
`endif

        if (vs_rise) begin
            frame_num_d = frame_num_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (vs_rise) pkt_idx_d = 16'h0000;
                if (level_ok) state_d = REQ;
            end

            REQ: begin
                tx_req = 1'b1;
                if (vs_rise) pkt_idx_d = 16'h0000;
                // An ack in the same cycle as a frame edge still starts the packet.
                if (tx_ack) begin
                    byte_cnt_d = 11'd0;
`ifdef PKT_HDR_EN
                    state_d     = HDR;
                    hdr_frame_d = frame_num_d;
`else
                    state_d     = PAYLOAD;
`endif
                end else if (vs_rise) begin
                    state_d = IDLE;
                end
            end

`ifdef PKT_HDR_EN
            HDR: begin
                // A frame edge here must not disturb the packet being sent;
                // the index clear waits for DONE.
                if (vs_rise) clr_pend_d = 1'b1;
                if (tx_data_rd) begin
                    case (byte_cnt_q[1:0])
                        2'd0:    tx_data_d = hdr_frame_q[15:8];
                        2'd1:    tx_data_d = hdr_frame_q[7:0];
                        2'd2:    tx_data_d = pkt_idx_q[15:8];
                        default: tx_data_d = pkt_idx_q[7:0];
                    endcase
                    if (byte_cnt_q[1:0] == 2'd3) begin
                        state_d    = PAYLOAD;
                        byte_cnt_d = 11'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 11'd1;
                    end
                end
            end
`endif

            PAYLOAD: begin
                if (vs_rise) clr_pend_d = 1'b1;
                if (tx_data_rd) begin
                    // An empty FIFO yields a 0x00 filler byte so the packet
                    // keeps its advertised length.
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        pay_sel_d  = 1'b1;
                    end else begin
                        tx_data_d = 8'h00;
                        pkt_err_d = 1'b1;
                    end
                    if (byte_cnt_q == LAST_C) begin
                        state_d    = DONE;
                        byte_cnt_d = 11'd0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 11'd1;
                    end
                end
            end

            DONE: begin
                state_d    = IDLE;
                clr_pend_d = 1'b0;
                if (clr_pend_q || vs_rise) pkt_idx_d = 16'h0000;
                else                       pkt_idx_d = pkt_idx_q + 16'd1;
            end

            default: state_d = IDLE;
        endcase
    end

    // Payload bytes come straight from the FIFO output register the cycle
    // after the pop; header and filler bytes come from tx_data_q.
    assign tx_data   = pay_sel_q ? fifo_data : tx_data_q;
    assign pkt_err   = pkt_err_q;
    assign frame_num = frame_num_q;
    assign dbg_state = state_q;
`ifdef PKT_HDR_EN
    assign udp_len   = 16'(PKT_LEN + 4);
`else
    assign udp_len   = 16'(PKT_LEN);
`endif

endmodule

// File: tb/tb_udp_img_packetizer.sv
// Bench for udp_img_packetizer: a small FIFO model feeds the DUT, every pulled
// byte's expected value is queued when the pull is driven and compared when
// the byte appears one cycle later.

module tb_udp_img_packetizer;

  localparam int PKT_LEN = 1024;
  localparam int CNT_W   = 11;
  localparam int NONE    = 99999;
`ifdef PKT_HDR_EN
  localparam int HDR_N = 4;
`else
  localparam int HDR_N = 0;
`endif

  logic             gmii_rx_clk;
  logic             rst_n;
  logic             cmos_vsync;
  logic [CNT_W-1:0] fifo_data_count;
  logic [7:0]       fifo_data;
  logic             fifo_rd_en;
  logic             tx_req;
  logic             tx_ack;
  logic             tx_data_rd;
  logic [7:0]       tx_data;
  logic [15:0]      udp_len;
  logic [15:0]      frame_num;
  logic             pkt_err;
  logic [2:0]       dbg_state;

  udp_img_packetizer #(.PKT_LEN(PKT_LEN), .CNT_W(CNT_W)) dut (
    .gmii_rx_clk     (gmii_rx_clk),
    .rst_n           (rst_n),
    .cmos_vsync      (cmos_vsync),
    .fifo_data_count (fifo_data_count),
    .fifo_data       (fifo_data),
    .fifo_rd_en      (fifo_rd_en),
    .tx_req          (tx_req),
    .tx_ack          (tx_ack),
    .tx_data_rd      (tx_data_rd),
    .tx_data         (tx_data),
    .udp_len         (udp_len),
    .frame_num       (frame_num),
    .pkt_err         (pkt_err),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    gmii_rx_clk = 1'b0;
    forever #5 gmii_rx_clk = ~gmii_rx_clk;
  end

  // ---------------- bench state ----------------
  int          checks   = 0;
  int          errors   = 0;
  int          level    = 0;   // model FIFO fill level
  int          pop_ptr  = 0;   // next byte index the model FIFO returns
  int          exp_ptr  = 0;   // next byte index the bench expects
  int          rd_seen  = 0;   // fifo_rd_en pulses observed
  int          err_seen = 0;   // pkt_err pulses observed
  logic [15:0] exp_frame = 16'h0000;
  logic [15:0] exp_idx   = 16'h0000;
  logic [7:0]  exp_q[$];

  function automatic logic [7:0] pat(input int n);
    return 8'((n * 37 + 11) & 255);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; drives inputs for one cycle, runs the FIFO
  // model after the rising edge, compares any queued byte, returns at the
  // next falling edge.
  task automatic clk_cycle(input logic rd, input logic ack);
    logic       pop;
    logic [7:0] e;
    tx_data_rd = rd;
    tx_ack     = ack;
    #1;
    pop = fifo_rd_en;
    if (pop) rd_seen++;
    @(posedge gmii_rx_clk);
    #1;
    tx_data_rd = 1'b0;
    tx_ack     = 1'b0;
    if (pop) begin
      fifo_data = pat(pop_ptr);
      pop_ptr++;
      if (level > 0) level--;
    end
    fifo_data_count = CNT_W'(level);
    #1;
    if (pkt_err) err_seen++;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("tx_data", {24'h0, tx_data}, {24'h0, e});
    end
    @(negedge gmii_rx_clk);
  endtask

  task automatic set_level(input int n);
    level = n;
    fifo_data_count = CNT_W'(n);
  endtask

  task automatic vsync_pulse();
    cmos_vsync = 1'b1;
    repeat (3) clk_cycle(1'b0, 1'b0);
    cmos_vsync = 1'b0;
    repeat (3) clk_cycle(1'b0, 1'b0);
    exp_frame = exp_frame + 16'd1;
    exp_idx   = 16'h0000;
  endtask

  task automatic wait_req(input string tag);
    int cyc;
    cyc = 0;
    while (!tx_req && cyc < 50) begin
      clk_cycle(1'b0, 1'b0);
      cyc++;
    end
    check(tag, {31'h0, tx_req}, 32'h1);
  endtask

  // One full packet; zero_at / vs_at / abort_at are payload byte positions
  // at which the FIFO empties, a frame sync arrives, or reset is applied.
  task automatic send_packet(input string tag, input int zero_at, input int vs_at, input int abort_at);
    int rd0, err0, exp_pops, exp_errs;
    set_level(PKT_LEN);
    clk_cycle(1'b0, 1'b0);
    wait_req({tag, "_req"});
    rd0 = rd_seen; err0 = err_seen; exp_pops = 0; exp_errs = 0;
    clk_cycle(1'b0, 1'b1);
    check({tag, "_req_low"}, {31'h0, tx_req}, 32'h0);
    for (int i = 0; i < HDR_N + PKT_LEN; i++) begin
      int p;
      p = i - HDR_N;
      if (p == abort_at) begin
        tx_data_rd = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
        check("rst_tx_req", {31'h0, tx_req}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_pkt_err", {31'h0, pkt_err}, 32'h0);
        check("rst_frame", {16'h0, frame_num}, 32'h0);
        check("rst_state", {29'h0, dbg_state}, 32'h0);
        tx_data_rd = 1'b0;
        exp_q.delete();
        exp_frame = 16'h0000;
        exp_idx   = 16'h0000;
        @(negedge gmii_rx_clk);
        rst_n = 1'b1;
        rd0 = rd_seen;
        repeat (8) clk_cycle(1'b1, 1'b0);
        check("rst_no_pop", rd_seen - rd0, 32'h0);
        check("rst_idle", {29'h0, dbg_state}, 32'h0);
        return;
      end
      if (p == zero_at) set_level(0);
      if (p == vs_at) cmos_vsync = 1'b1;
      if (p == vs_at + 4) cmos_vsync = 1'b0;
      if (i < HDR_N) begin
        case (i)
          0:       exp_q.push_back(exp_frame[15:8]);
          1:       exp_q.push_back(exp_frame[7:0]);
          2:       exp_q.push_back(exp_idx[15:8]);
          default: exp_q.push_back(exp_idx[7:0]);
        endcase
      end else if (level > 0) begin
        exp_q.push_back(pat(exp_ptr));
        exp_ptr++;
        exp_pops++;
      end else begin
        exp_q.push_back(8'h00);
        exp_errs++;
      end
      clk_cycle(1'b1, 1'b0);
    end
    if (vs_at != NONE) begin
      exp_frame = exp_frame + 16'd1;
      exp_idx   = 16'h0000;
    end else begin
      exp_idx = exp_idx + 16'd1;
    end
    // A pull after the last byte must be ignored.
    clk_cycle(1'b1, 1'b0);
    clk_cycle(1'b0, 1'b0);
    check({tag, "_pops"}, rd_seen - rd0, exp_pops);
    check({tag, "_errs"}, err_seen - err0, exp_errs);
    check({tag, "_idle"}, {29'h0, dbg_state}, 32'h0);
    check({tag, "_frame"}, {16'h0, frame_num}, {16'h0, exp_frame});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    cmos_vsync = 1'b0;
    tx_ack = 1'b0;
    tx_data_rd = 1'b0;
    fifo_data = 8'h00;
    fifo_data_count = '0;
    #12;
    check("reset_tx_req", {31'h0, tx_req}, 32'h0);
    check("reset_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    check("reset_tx_data", {24'h0, tx_data}, 32'h0);
    check("reset_pkt_err", {31'h0, pkt_err}, 32'h0);
    check("reset_frame", {16'h0, frame_num}, 32'h0);
    check("reset_state", {29'h0, dbg_state}, 32'h0);
    check("udp_len", {16'h0, udp_len}, PKT_LEN + HDR_N);
    @(negedge gmii_rx_clk);
    rst_n = 1'b1;
    clk_cycle(1'b0, 1'b0);
    // A FIFO one byte short of a packet must not raise a request.
    set_level(PKT_LEN - 1);
    repeat (3) clk_cycle(1'b0, 1'b0);
    check("short_no_req", {31'h0, tx_req}, 32'h0);

    send_packet("pkt0", NONE, NONE, NONE);
    send_packet("pkt1", NONE, NONE, NONE);
    set_level(0);
    vsync_pulse();
    check("vs_frame1", {16'h0, frame_num}, {16'h0, exp_frame});
    send_packet("pkt2", NONE, NONE, NONE);

    // FIFO runs dry after 1000 payload bytes.
    send_packet("under", 1000, NONE, NONE);

    // Frame sync mid-payload: packet completes, index clears at DONE.
    send_packet("vsmid", NONE, 10, NONE);
    send_packet("after_vs", NONE, NONE, NONE);

    // Frame sync while waiting in REQ with no acknowledge.
    set_level(PKT_LEN);
    clk_cycle(1'b0, 1'b0);
    wait_req("vsreq_req");
    set_level(0);
    cmos_vsync = 1'b1;
    clk_cycle(1'b0, 1'b0);
    clk_cycle(1'b0, 1'b0);
    check("vsreq_still_req", {31'h0, tx_req}, 32'h1);
    clk_cycle(1'b0, 1'b0);
    check("vsreq_req_drop", {31'h0, tx_req}, 32'h0);
    check("vsreq_idle", {29'h0, dbg_state}, 32'h0);
    cmos_vsync = 1'b0;
    repeat (3) clk_cycle(1'b0, 1'b0);
    exp_frame = exp_frame + 16'd1;
    exp_idx   = 16'h0000;
    check("vsreq_frame", {16'h0, frame_num}, {16'h0, exp_frame});

    // Frame counter wrap.
    force dut.frame_num_q = 16'hFFFF;
    clk_cycle(1'b0, 1'b0);
    release dut.frame_num_q;
    clk_cycle(1'b0, 1'b0);
    check("wrap_pre", {16'h0, frame_num}, 32'hFFFF);
    exp_frame = 16'hFFFF;
    vsync_pulse();
    check("wrap_post", {16'h0, frame_num}, {16'h0, exp_frame});
    send_packet("post_wrap", NONE, NONE, NONE);

    // Reset in the middle of the payload.
    send_packet("abort", NONE, NONE, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
